// File: rtl/keccak_pkg.sv
// Shared widths, types and FSM encoding for the Keccak state transposer.
package keccak_pkg;

   localparam int SLICE_W     = 25;
   localparam int LANE_W      = 64;
   localparam int LANE_IDX_W  = 5;
   localparam int SLICE_IDX_W = 6;

   typedef logic [SLICE_W-1:0] slice_t;
   typedef logic [LANE_W-1:0]  lane_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      LANE  = 2'd2,
      DRAIN = 2'd3
   } xpose_state_e;

endpackage

// File: rtl/keccak_state_mem.sv
// SLICES x LANES state array: row port addresses a slice, column port a lane.
module keccak_state_mem
   import keccak_pkg::*;
#(
   parameter int SLICES = 64,
   parameter int LANES  = 25
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   row_we_i,
   input  logic [SLICE_IDX_W-1:0] row_waddr_i,
   input  logic [LANES-1:0]       row_wdata_i,
   input  logic [SLICE_IDX_W-1:0] row_raddr_i,
   output logic [LANES-1:0]       row_rdata_o,
   input  logic                   col_we_i,
   input  logic [LANE_IDX_W-1:0]  col_widx_i,
   input  logic [SLICES-1:0]      col_wdata_i,
   input  logic [LANE_IDX_W-1:0]  col_ridx_i,
   output logic [SLICES-1:0]      col_rdata_o
);

   logic [SLICES-1:0][LANES-1:0] mem_q;
   logic                         col_wok;
   logic                         col_rok;

   assign col_wok = col_widx_i < LANE_IDX_W'(LANES);
   assign col_rok = col_ridx_i < LANE_IDX_W'(LANES);

   // Row and column writes are never enabled together (LOAD vs LANE phase).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '0;
      end else begin
         if (row_we_i)
            mem_q[row_waddr_i] <= row_wdata_i;
         if (col_we_i && col_wok)
            for (int j = 0; j < SLICES; j++)
               mem_q[j][col_widx_i] <= col_wdata_i[j];
      end
   end

   assign row_rdata_o = mem_q[row_raddr_i];

   always_comb begin
      col_rdata_o = '0;
      if (col_rok)
         for (int j = 0; j < SLICES; j++)
            col_rdata_o[j] = mem_q[j][col_ridx_i];
   end

endmodule

// File: rtl/keccak_state_transposer.sv
// Slice-in / lane-random-access / slice-out buffer for the Keccak-f[1600] state.
module keccak_state_transposer
   import keccak_pkg::*;
#(
   parameter int SLICES = 64,
   parameter int LANES  = 25
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LANES-1:0]      slice_in,
   input  logic                  slice_in_valid,
   output logic                  slice_in_ready,
   input  logic                  lane_rd_req,
   input  logic [LANE_IDX_W-1:0] lane_rd_idx,
   output logic [SLICES-1:0]     lane_out,
   output logic                  lane_rd_valid,
   input  logic                  lane_wr_en,
   input  logic [LANE_IDX_W-1:0] lane_wr_idx,
   input  logic [SLICES-1:0]     lane_wr_data,
   input  logic                  lanes_done,
   output logic [LANES-1:0]      slice_out,
   output logic                  slice_out_valid,
   input  logic                  slice_out_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  idx_err
);

   localparam logic [SLICE_IDX_W-1:0] LAST = SLICE_IDX_W'(SLICES - 1);

   xpose_state_e           state_q;
   logic [SLICE_IDX_W-1:0] in_cnt_q, out_cnt_q;
   logic [SLICES-1:0]      lane_out_q;
   logic                   lane_rd_valid_q, done_q, idx_err_q;
   logic [SLICES-1:0]      col_rdata;
   logic                   in_hs, out_hs, in_lane, rd_bad, wr_bad;

   assign in_hs   = (state_q == LOAD) && slice_in_valid;
   assign out_hs  = (state_q == DRAIN) && slice_out_ready;
   assign in_lane = (state_q == LANE);
   assign rd_bad  = lane_rd_idx >= LANE_IDX_W'(LANES);
   assign wr_bad  = lane_wr_idx >= LANE_IDX_W'(LANES);

   keccak_state_mem #(.SLICES(SLICES), .LANES(LANES)) u_mem (
      .clk         (clk),
      .rst         (rst),
      .row_we_i    (in_hs),
      .row_waddr_i (in_cnt_q),
      .row_wdata_i (slice_in),
      .row_raddr_i (out_cnt_q),
      .row_rdata_o (slice_out),
      .col_we_i    (in_lane && lane_wr_en),
      .col_widx_i  (lane_wr_idx),
      .col_wdata_i (lane_wr_data),
      .col_ridx_i  (lane_rd_idx),
      .col_rdata_o (col_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         in_cnt_q        <= '0;
         out_cnt_q       <= '0;
         lane_out_q      <= '0;
         lane_rd_valid_q <= 1'b0;
         done_q          <= 1'b0;
         idx_err_q       <= 1'b0;
      end else begin
         lane_rd_valid_q <= 1'b0;
         done_q          <= 1'b0;
         case (state_q)
            IDLE: begin
               in_cnt_q  <= '0;
               out_cnt_q <= '0;
               if (start) begin
                  state_q   <= LOAD;
                  idx_err_q <= 1'b0;
               end
            end
            LOAD: begin
               if (in_hs) begin
                  in_cnt_q <= in_cnt_q + 1'b1;
                  if (in_cnt_q == LAST)
                     state_q <= LANE;
               end
            end
            LANE: begin
               // The column read sees storage before this cycle's lane write.
               if (lane_rd_req) begin
                  lane_out_q      <= col_rdata;
                  lane_rd_valid_q <= 1'b1;
               end
               if ((lane_rd_req && rd_bad) || (lane_wr_en && wr_bad))
                  idx_err_q <= 1'b1;
               if (lanes_done)
                  state_q <= DRAIN;
            end
            DRAIN: begin
               if (out_hs) begin
                  out_cnt_q <= out_cnt_q + 1'b1;
                  if (out_cnt_q == LAST) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign slice_in_ready  = (state_q == LOAD);
   assign slice_out_valid = (state_q == DRAIN);
   assign busy            = (state_q != IDLE);
   assign lane_out        = lane_out_q;
   assign lane_rd_valid   = lane_rd_valid_q;
   assign done            = done_q;
   assign idx_err         = idx_err_q;

endmodule

// File: tb/tb_keccak_state_transposer.sv
// Randomized bench for keccak_state_transposer against a lane-oriented state model.
module tb_keccak_state_transposer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [24:0] slice_in;
   logic        slice_in_valid;
   logic        slice_in_ready;
   logic        lane_rd_req;
   logic [4:0]  lane_rd_idx;
   logic [63:0] lane_out;
   logic        lane_rd_valid;
   logic        lane_wr_en;
   logic [4:0]  lane_wr_idx;
   logic [63:0] lane_wr_data;
   logic        lanes_done;
   logic [24:0] slice_out;
   logic        slice_out_valid;
   logic        slice_out_ready;
   logic        busy;
   logic        done;
   logic        idx_err;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: the state as 25 lanes of 64 bits; a slice is bit i of every lane.
   logic [63:0] m_lane [25];
   logic [24:0] ld_buf [64];
   logic [24:0] got_buf [64];
   int          drained;

   keccak_state_transposer dut (
      .clk(clk), .rst(rst), .start(start),
      .slice_in(slice_in), .slice_in_valid(slice_in_valid), .slice_in_ready(slice_in_ready),
      .lane_rd_req(lane_rd_req), .lane_rd_idx(lane_rd_idx),
      .lane_out(lane_out), .lane_rd_valid(lane_rd_valid),
      .lane_wr_en(lane_wr_en), .lane_wr_idx(lane_wr_idx), .lane_wr_data(lane_wr_data),
      .lanes_done(lanes_done),
      .slice_out(slice_out), .slice_out_valid(slice_out_valid), .slice_out_ready(slice_out_ready),
      .busy(busy), .done(done), .idx_err(idx_err)
   );

   always #5 clk = ~clk;

   function automatic logic [24:0] exp_slice(input int i);
      logic [24:0] s;
      for (int b = 0; b < 25; b++) s[b] = m_lane[b][i];
      return s;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      start = 0; slice_in = '0; slice_in_valid = 0;
      lane_rd_req = 0; lane_rd_idx = '0; lane_wr_en = 0; lane_wr_idx = '0;
      lane_wr_data = '0; lanes_done = 0; slice_out_ready = 0;
      rst = 1;
      for (int b = 0; b < 25; b++) m_lane[b] = '0;
      repeat (2) tick();
      rst = 0;
      tick();
   endtask

   // Loads ld_buf[0..n-1] with random idle gaps; a full load updates the model.
   task automatic load_n(input int n);
      start = 1; tick(); start = 0;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin slice_in_valid = 0; tick(); end
         slice_in = ld_buf[i]; slice_in_valid = 1; tick();
      end
      slice_in_valid = 0;
      if (n == 64)
         for (int i = 0; i < 64; i++)
            for (int b = 0; b < 25; b++) m_lane[b][i] = ld_buf[i][b];
   endtask

   task automatic end_lanes();
      lanes_done = 1; tick(); lanes_done = 0;
   endtask

   task automatic drain(output int ndone);
      int cyc = 0;
      ndone = 0; drained = 0;
      while (drained < 64 && cyc < 2000) begin
         slice_out_ready = ($urandom_range(0, 3) != 0);
         if (slice_out_ready && slice_out_valid) begin
            got_buf[drained] = slice_out; drained++;
         end
         tick(); cyc++;
         if (done) ndone++;
      end
      slice_out_ready = 0;
      repeat (2) begin tick(); if (done) ndone++; end
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if ({busy, done, slice_in_ready, slice_out_valid, lane_rd_valid, idx_err} !== 6'b0)
         $display("FAIL reset_flags got %b exp 000000",
                  {busy, done, slice_in_ready, slice_out_valid, lane_rd_valid, idx_err});
      else n_pass++;
      n_chk++;
      if (lane_out !== 64'h0 || slice_out !== 25'h0)
         $display("FAIL reset_data got lane %h slice %h exp 0", lane_out, slice_out);
      else n_pass++;
   endtask

   task automatic test_roundtrip();
      int nd, bad;
      do_reset();
      for (int i = 0; i < 64; i++) ld_buf[i] = 25'(i);
      start = 1; tick(); start = 0;
      n_chk++;
      if (slice_in_ready !== 1'b1 || busy !== 1'b1)
         $display("FAIL start_ready got rdy %b busy %b exp 1 1", slice_in_ready, busy);
      else n_pass++;
      for (int i = 0; i < 64; i++) begin
         slice_in = ld_buf[i]; slice_in_valid = 1; tick();
      end
      slice_in_valid = 0;
      for (int i = 0; i < 64; i++)
         for (int b = 0; b < 25; b++) m_lane[b][i] = ld_buf[i][b];
      end_lanes();
      n_chk++;
      if (slice_out_valid !== 1'b1 || slice_out !== 25'h0)
         $display("FAIL drain_entry got vld %b slice %h exp 1 0", slice_out_valid, slice_out);
      else n_pass++;
      drain(nd);
      n_chk++;
      bad = 0;
      for (int i = 0; i < drained; i++)
         if (got_buf[i] !== 25'(i)) begin
            bad++;
            $display("FAIL roundtrip slice %0d got %h exp %h", i, got_buf[i], 25'(i));
         end
      if (drained != 64) $display("FAIL roundtrip_count got %0d exp 64", drained);
      if (bad == 0 && drained == 64) n_pass++;
      n_chk++;
      if (nd != 1 || busy !== 1'b0)
         $display("FAIL done_pulse got %0d pulses busy %b exp 1 0", nd, busy);
      else n_pass++;
   endtask

   task automatic test_lane_read();
      do_reset();
      for (int i = 0; i < 64; i++) ld_buf[i] = (i % 2 == 0) ? 25'h1 : 25'h0;
      load_n(64);
      lane_rd_req = 1; lane_rd_idx = 5'd0; tick();
      n_chk++;
      if (lane_out !== 64'h5555_5555_5555_5555 || lane_rd_valid !== 1'b1)
         $display("FAIL read_lane0 got %h vld %b exp 5555555555555555 1", lane_out, lane_rd_valid);
      else n_pass++;
      lane_rd_idx = 5'd1; tick(); lane_rd_req = 0;
      n_chk++;
      if (lane_out !== 64'h0) $display("FAIL read_lane1 got %h exp 0", lane_out);
      else n_pass++;
      tick();
      n_chk++;
      if (lane_rd_valid !== 1'b0) $display("FAIL rd_valid_pulse got %b exp 0", lane_rd_valid);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      do_reset();
      for (int i = 0; i < 64; i++) ld_buf[i] = 25'($urandom);
      load_n(64);
      lane_rd_req = 1;
      for (int k = 0; k < 25; k++) begin
         lane_rd_idx = 5'(k); tick();
         if (lane_out !== m_lane[k] || lane_rd_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_read lane %0d got %h exp %h", k, lane_out, m_lane[k]);
         end
      end
      lane_rd_req = 0;
      n_chk++;
      if (bad == 0) n_pass++;
   endtask

   task automatic test_lane_write();
      int nd, bad;
      do_reset();
      for (int i = 0; i < 64; i++) ld_buf[i] = 25'h0;
      load_n(64);
      lane_wr_en = 1; lane_wr_idx = 5'd24; lane_wr_data = '1; tick(); lane_wr_en = 0;
      m_lane[24] = '1;
      end_lanes();
      drain(nd);
      n_chk++;
      bad = 0;
      for (int i = 0; i < 64; i++)
         if (got_buf[i] !== 25'h100_0000) begin
            bad++;
            $display("FAIL wr_lane24 slice %0d got %h exp 1000000", i, got_buf[i]);
         end
      if (bad == 0 && drained == 64) n_pass++;
      // Random writes (final cycle overlaps lanes_done) checked through a full drain.
      do_reset();
      for (int i = 0; i < 64; i++) ld_buf[i] = 25'($urandom);
      load_n(64);
      for (int k = 0; k < 12; k++) begin
         lane_wr_en = 1; lane_wr_idx = 5'($urandom_range(0, 24));
         lane_wr_data = {$urandom, $urandom};
         m_lane[lane_wr_idx] = lane_wr_data;
         if (k == 11) lanes_done = 1;
         tick();
      end
      lane_wr_en = 0; lanes_done = 0;
      drain(nd);
      n_chk++;
      bad = 0;
      for (int i = 0; i < 64; i++)
         if (got_buf[i] !== exp_slice(i)) begin
            bad++;
            $display("FAIL rand_write slice %0d got %h exp %h", i, got_buf[i], exp_slice(i));
         end
      if (bad == 0 && drained == 64 && nd == 1) n_pass++;
   endtask

   task automatic test_collision();
      do_reset();
      for (int i = 0; i < 64; i++) ld_buf[i] = 25'h0;
      load_n(64);
      lane_rd_req = 1; lane_rd_idx = 5'd3;
      lane_wr_en = 1; lane_wr_idx = 5'd3; lane_wr_data = '1;
      tick();
      lane_wr_en = 0;
      n_chk++;
      if (lane_out !== 64'h0) $display("FAIL collide_old got %h exp 0", lane_out);
      else n_pass++;
      tick(); lane_rd_req = 0;
      n_chk++;
      if (lane_out !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL collide_new got %h exp all-ones", lane_out);
      else n_pass++;
   endtask

   task automatic test_bad_idx_backpressure();
      int nd, bad;
      logic [24:0] s0;
      do_reset();
      for (int i = 0; i < 64; i++) ld_buf[i] = 25'($urandom);
      load_n(64);
      lane_rd_req = 1; lane_rd_idx = 5'd7; tick();
      lane_rd_idx = 5'd27; tick(); lane_rd_req = 0;
      n_chk++;
      if (lane_out !== 64'h0 || lane_rd_valid !== 1'b1 || idx_err !== 1'b1)
         $display("FAIL bad_read got %h vld %b err %b exp 0 1 1", lane_out, lane_rd_valid, idx_err);
      else n_pass++;
      lane_wr_en = 1; lane_wr_idx = 5'd30; lane_wr_data = {$urandom, $urandom}; tick();
      lane_wr_en = 0;
      end_lanes();
      s0 = slice_out;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_chk++;
         if (slice_out !== exp_slice(0) || slice_out !== s0 || slice_out_valid !== 1'b1)
            $display("FAIL backpressure cyc %0d got %h exp %h", k, slice_out, exp_slice(0));
         else n_pass++;
      end
      drain(nd);
      n_chk++;
      bad = 0;
      for (int i = 0; i < 64; i++)
         if (got_buf[i] !== exp_slice(i)) begin
            bad++;
            $display("FAIL bp_drain slice %0d got %h exp %h", i, got_buf[i], exp_slice(i));
         end
      if (bad == 0 && drained == 64) n_pass++;
      n_chk++;
      if (idx_err !== 1'b1) $display("FAIL err_sticky got %b exp 1", idx_err);
      else n_pass++;
      start = 1; tick(); start = 0;
      n_chk++;
      if (idx_err !== 1'b0) $display("FAIL err_clear got %b exp 0", idx_err);
      else n_pass++;
   endtask

   task automatic test_reset_mid_load();
      int nd, bad;
      do_reset();
      for (int i = 0; i < 64; i++) ld_buf[i] = 25'($urandom);
      load_n(30);
      rst = 1; #2;
      n_chk++;
      if ({busy, slice_in_ready, slice_out_valid, done, lane_rd_valid, idx_err} !== 6'b0 ||
          slice_out !== 25'h0 || lane_out !== 64'h0)
         $display("FAIL mid_reset got busy %b rdy %b slice %h exp 0", busy, slice_in_ready, slice_out);
      else n_pass++;
      tick(); rst = 0;
      for (int b = 0; b < 25; b++) m_lane[b] = '0;
      repeat (3) tick();
      n_chk++;
      if (busy !== 1'b0 || slice_in_ready !== 1'b0)
         $display("FAIL wait_start got busy %b rdy %b exp 0 0", busy, slice_in_ready);
      else n_pass++;
      for (int i = 0; i < 64; i++) ld_buf[i] = 25'($urandom);
      load_n(64);
      end_lanes();
      drain(nd);
      n_chk++;
      bad = 0;
      for (int i = 0; i < 64; i++)
         if (got_buf[i] !== exp_slice(i)) begin
            bad++;
            $display("FAIL reload slice %0d got %h exp %h", i, got_buf[i], exp_slice(i));
         end
      if (bad == 0 && drained == 64 && nd == 1) n_pass++;
   endtask

   initial begin
      test_reset();
      test_roundtrip();
      test_lane_read();
      test_back_to_back();
      test_lane_write();
      test_collision();
      test_bad_idx_backpressure();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
